// File: rtl/uart_tx_parity.sv
// UART transmitter: start, N_BITS_DATA data bits (LSB first), optional parity, stop.
// Bits are paced by s_ticks; one bit lasts 2^N_CONT_TICKS ticks.
// Ports:
//   clock, reset     - system clock, synchronous active-high reset
//   s_ticks          - baud-tick strobe (16 per bit by default)
//   tx_start         - send request, sampled only while idle
//   data_i           - byte to send, latched on acceptance
//   tx_o             - serial line, idle high (registered)
//   tx_busy          - high while a frame is in flight (registered)
//   tx_done_tick     - one-clock pulse after the stop bit ends (registered)
module uart_tx_parity #(
   parameter int unsigned N_BITS_DATA  = 8,
   parameter int unsigned N_CONT_TICKS = 4,
   parameter int unsigned N_BITS_STATE = 5,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   s_ticks,
   input  logic                   tx_start,
   input  logic [N_BITS_DATA-1:0] data_i,
   output logic                   tx_o,
   output logic                   tx_busy,
   output logic                   tx_done_tick
);

   localparam int unsigned BIT_CNT_W = (N_BITS_DATA > 1) ? $clog2(N_BITS_DATA) : 1;
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(N_BITS_DATA - 1);
   localparam logic PAR_EN_B  = (PARITY_EN != 0);
   localparam logic PAR_ODD_B = (PARITY_ODD != 0);

   typedef enum logic [N_BITS_STATE-1:0] {
      S_IDLE   = N_BITS_STATE'(5'b00001),
      S_START  = N_BITS_STATE'(5'b00010),
      S_DATA   = N_BITS_STATE'(5'b00100),
      S_PARITY = N_BITS_STATE'(5'b01000),
      S_STOP   = N_BITS_STATE'(5'b10000)
   } state_t;

   state_t                   state_q,  state_d;
   logic [N_CONT_TICKS-1:0]  tick_q,   tick_d;
   logic [BIT_CNT_W-1:0]     bit_q,    bit_d;
   logic [N_BITS_DATA-1:0]   shift_q,  shift_d;
   logic                     parity_q, parity_d;
   logic                     tx_q,     tx_d;
   logic                     busy_q,   busy_d;
   logic                     done_q,   done_d;
   logic                     bit_end_c;

   // Next-state logic; outputs are precomputed from the next state so they are flops.
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      done_d   = 1'b0;
      tx_d     = 1'b1;
      busy_d   = 1'b0;

      // Bit end: the tick on which the tick counter wraps back to zero.
      bit_end_c = s_ticks && (tick_q == {N_CONT_TICKS{1'b1}});

      if ((state_q != S_IDLE) && s_ticks) begin
         tick_d = tick_q + N_CONT_TICKS'(1);
      end

      case (state_q)
         S_IDLE: begin
            tick_d = '0;
            if (tx_start) begin
               shift_d  = data_i;
               parity_d = (^data_i) ^ PAR_ODD_B;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (bit_end_c) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end_c) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + BIT_CNT_W'(1);
               if (bit_q == BIT_LAST) begin
                  state_d = PAR_EN_B ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (bit_end_c) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end_c) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Line level for the cycle after this edge.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = parity_d;
         default:  tx_d = 1'b1;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign tx_o         = tx_q;
   assign tx_busy      = busy_q;
   assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: three instances (even parity, odd parity, no parity)
// checked every cycle against a frame-level reference model, plus directed
// mid-bit sampling and a loopback receiver on instance 0.
module tb_uart_tx_parity;

   localparam int NDUT = 3;

   logic clock   = 1'b0;
   logic reset   = 1'b1;
   logic s_ticks = 1'b0;
   logic       tx_start     [NDUT];
   logic [7:0] data_i       [NDUT];
   logic       tx_o         [NDUT];
   logic       tx_busy      [NDUT];
   logic       tx_done_tick [NDUT];

   bit par_en_c  [NDUT] = '{1'b1, 1'b1, 1'b0};
   bit par_odd_c [NDUT] = '{1'b0, 1'b1, 1'b0};

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt [NDUT] = '{0, 0, 0};
   bit chk_en = 1'b0;

   // reference model state
   bit          m_busy  [NDUT];
   bit          m_done  [NDUT];
   int          m_ticks [NDUT];
   int          m_nb    [NDUT];
   logic [10:0] m_bits  [NDUT];

   // loopback receiver on instance 0
   logic [7:0] rx_q [$];
   int         rx_err = 0;

   initial forever #5 clock = ~clock;

   uart_tx_parity #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
      .clock(clock), .reset(reset), .s_ticks(s_ticks), .tx_start(tx_start[0]),
      .data_i(data_i[0]), .tx_o(tx_o[0]), .tx_busy(tx_busy[0]), .tx_done_tick(tx_done_tick[0]));
   uart_tx_parity #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
      .clock(clock), .reset(reset), .s_ticks(s_ticks), .tx_start(tx_start[1]),
      .data_i(data_i[1]), .tx_o(tx_o[1]), .tx_busy(tx_busy[1]), .tx_done_tick(tx_done_tick[1]));
   uart_tx_parity #(.PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
      .clock(clock), .reset(reset), .s_ticks(s_ticks), .tx_start(tx_start[2]),
      .data_i(data_i[2]), .tx_o(tx_o[2]), .tx_busy(tx_busy[2]), .tx_done_tick(tx_done_tick[2]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Random tick strobe, about one clock in two.
   initial forever begin
      @(negedge clock);
      s_ticks = ($urandom_range(0, 1) == 1);
   end

   // Frame-level model: a frame is a list of bits, each lasting 16 ticks.
   initial begin
      int ones;
      for (int k = 0; k < NDUT; k++) begin
         m_busy[k] = 0; m_done[k] = 0; m_ticks[k] = 0; m_nb[k] = 11; m_bits[k] = '1;
      end
      forever begin
         @(posedge clock);
         for (int k = 0; k < NDUT; k++) begin
            if (reset) begin
               m_busy[k] = 0; m_done[k] = 0; m_ticks[k] = 0;
            end else begin
               m_done[k] = 0;
               if (!m_busy[k]) begin
                  if (tx_start[k] === 1'b1) begin
                     ones = 0;
                     m_bits[k] = '0;
                     for (int i = 0; i < 8; i++) begin
                        ones += int'(data_i[k][i]);
                        m_bits[k][1+i] = data_i[k][i];
                     end
                     if (par_en_c[k]) begin
                        m_bits[k][9] = 1'((ones % 2) ^ int'(par_odd_c[k]));
                        m_nb[k] = 11;
                     end else begin
                        m_nb[k] = 10;
                     end
                     m_bits[k][m_nb[k]-1] = 1'b1;
                     m_busy[k]  = 1;
                     m_ticks[k] = 0;
                  end
               end else if (s_ticks) begin
                  m_ticks[k]++;
                  if (m_ticks[k] == 16 * m_nb[k]) begin
                     m_busy[k] = 0;
                     m_done[k] = 1;
                  end
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial forever begin
      logic exp_tx;
      @(negedge clock);
      for (int k = 0; k < NDUT; k++) begin
         if (tx_done_tick[k] === 1'b1) done_cnt[k]++;
         if (chk_en) begin
            exp_tx = m_busy[k] ? m_bits[k][m_ticks[k] / 16] : 1'b1;
            check_val($sformatf("tx_o[%0d]", k), 32'(tx_o[k]), 32'(exp_tx));
            check_val($sformatf("tx_busy[%0d]", k), 32'(tx_busy[k]), 32'(m_busy[k]));
            check_val($sformatf("tx_done_tick[%0d]", k), 32'(tx_done_tick[k]), 32'(m_done[k]));
         end
      end
   end

   // Loopback receiver: samples mid-bit, checks stop and even parity.
   initial begin
      bit         act = 0;
      int         cnt = 0;
      int         idx;
      logic [7:0] sh = '0;
      logic       par = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (reset) begin
            act = 0;
         end else if (s_ticks) begin
            if (!act) begin
               if (tx_o[0] === 1'b0) begin
                  act = 1; cnt = 0;
               end
            end else begin
               cnt++;
               if (cnt % 16 == 8) begin
                  idx = cnt / 16;
                  if (idx >= 1 && idx <= 8) sh[idx-1] = tx_o[0];
                  else if (idx == 9) par = tx_o[0];
                  else if (idx == 10) begin
                     if (tx_o[0] !== 1'b1 || par !== ^sh) rx_err++;
                     rx_q.push_back(sh);
                     act = 0;
                  end
               end
            end
         end
      end
   end

   task automatic start_frame(input int k, input logic [7:0] d);
      @(negedge clock);
      data_i[k]   = d;
      tx_start[k] = 1'b1;
      @(negedge clock);
      tx_start[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int max_cyc);
      int c = 0;
      while (tx_done_tick[k] !== 1'b1 && c < max_cyc) begin
         @(negedge clock);
         c++;
      end
      check_val($sformatf("done_wait[%0d]", k), 32'(tx_done_tick[k]), 32'd1);
   endtask

   // Send one frame and sample the line in the middle of each bit.
   task automatic send_sample(input int k, input logic [7:0] d, input int nb, input logic [10:0] exp);
      int cnt = 0;
      int i   = 0;
      int cyc = 0;
      start_frame(k, d);
      while (i < nb && cyc < 20000) begin
         @(posedge clock);
         cyc++;
         if (s_ticks) begin
            cnt++;
            if (cnt == 16 * i + 8) begin
               #1;
               check_val($sformatf("bit%0d[%0d]", i, k), 32'(tx_o[k]), 32'(exp[i]));
               i++;
            end
         end
      end
      check_val($sformatf("sample_count[%0d]", k), 32'(i), 32'(nb));
      @(negedge clock);
      wait_done(k, 2000);
      @(negedge clock);
   endtask

   initial begin
      int dc;
      int tk;
      int c;
      int k;
      for (int j = 0; j < NDUT; j++) begin
         tx_start[j] = 1'b0;
         data_i[j]   = '0;
      end
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk_en = 1'b1;
      @(negedge clock);
      for (int j = 0; j < NDUT; j++) begin
         check_val($sformatf("rst_tx_o[%0d]", j), 32'(tx_o[j]), 32'd1);
         check_val($sformatf("rst_busy[%0d]", j), 32'(tx_busy[j]), 32'd0);
         check_val($sformatf("rst_done[%0d]", j), 32'(tx_done_tick[j]), 32'd0);
      end
      reset = 1'b0;
      repeat (3) @(negedge clock);

      // even parity 0xA5: 0,1,0,1,0,0,1,0,1,0,1
      send_sample(0, 8'hA5, 11, 11'b10101001010);
      check_val("done_cnt_a5", 32'(done_cnt[0]), 32'd1);

      // odd parity: 0x01 -> parity 0, 0x00 -> parity 1
      send_sample(1, 8'h01, 11, 11'b10000000010);
      send_sample(1, 8'h00, 11, 11'b11000000000);

      // no parity slot
      send_sample(2, 8'hFF, 10, 11'b01111111110);
      check_val("done_cnt_nopar", 32'(done_cnt[2]), 32'd1);

      // start request while busy is ignored
      dc = done_cnt[0];
      start_frame(0, 8'h96);
      repeat (60) @(negedge clock);
      data_i[0]   = 8'h3C;
      tx_start[0] = 1'b1;
      @(negedge clock);
      tx_start[0] = 1'b0;
      wait_done(0, 2000);
      repeat (800) @(negedge clock);
      check_val("busy_ignore_cnt", 32'(done_cnt[0]), 32'(dc + 1));
      check_val("busy_ignore_idle", 32'(tx_busy[0]), 32'd0);

      // reset in the middle of the data bits aborts the frame
      start_frame(0, 8'h5A);
      tk = 0; c = 0;
      while (tk < 40 && c < 5000) begin
         @(posedge clock);
         c++;
         if (s_ticks) tk++;
      end
      @(negedge clock);
      check_val("pre_rst_busy", 32'(tx_busy[0]), 32'd1);
      dc = done_cnt[0];
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_val("abort_tx_o", 32'(tx_o[0]), 32'd1);
      check_val("abort_busy", 32'(tx_busy[0]), 32'd0);
      repeat (800) @(negedge clock);
      check_val("abort_no_done", 32'(done_cnt[0]), 32'(dc));
      send_sample(0, 8'h3C, 11, 11'b10001111000);

      // back-to-back with tx_start held high, decoded by the loopback receiver
      rx_q.delete();
      rx_err = 0;
      dc = done_cnt[0];
      @(negedge clock);
      data_i[0]   = 8'h55;
      tx_start[0] = 1'b1;
      @(negedge clock);
      data_i[0]   = 8'hC3;
      wait_done(0, 2000);
      @(negedge clock);
      check_val("b2b_accept", 32'(tx_busy[0]), 32'd1);
      tx_start[0] = 1'b0;
      wait_done(0, 2000);
      repeat (40) @(negedge clock);
      check_val("b2b_done_cnt", 32'(done_cnt[0]), 32'(dc + 2));
      check_val("b2b_rx_count", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() >= 2) begin
         check_val("b2b_rx0", 32'(rx_q[0]), 32'h55);
         check_val("b2b_rx1", 32'(rx_q[1]), 32'hC3);
      end
      check_val("b2b_rx_err", 32'(rx_err), 32'd0);

      // randomized frames with spurious start requests while busy
      for (int r = 0; r < 24; r++) begin
         k = $urandom_range(0, NDUT - 1);
         start_frame(k, 8'($urandom));
         c = 0;
         while (tx_done_tick[k] !== 1'b1 && c < 3000) begin
            if ($urandom_range(0, 39) == 0) begin
               tx_start[k] = 1'b1;
               data_i[k]   = 8'($urandom);
            end else begin
               tx_start[k] = 1'b0;
            end
            @(negedge clock);
            c++;
         end
         tx_start[k] = 1'b0;
         check_val($sformatf("rand_done[%0d]", r), 32'(tx_done_tick[k]), 32'd1);
         repeat ($urandom_range(1, 20)) @(negedge clock);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_parity.md
Name: uart_tx_parity

Overview:
UART transmitter that serializes one byte per frame onto a single line. Frame order is start, N_BITS_DATA data bits LSB first, one parity bit, one stop bit. It paces bits from the shared 16x baud-tick generator (s_ticks), so it is frame-compatible with the UART receiver on the same tick source. It sits between the RX/TX interface logic (which supplies data_i and tx_start) and the board TX pin.

Parameters:
N_BITS_DATA, 8, data bits per frame.
N_CONT_TICKS, 4, width of the tick counter; one bit lasts 2^N_CONT_TICKS = 16 s_ticks.
N_BITS_STATE, 5, state register width (one-hot).
PARITY_EN, 1, 1 = parity bit present; 0 = parity bit omitted.
PARITY_ODD, 0, 0 = even parity; 1 = odd parity.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
s_ticks  input  1  baud-tick strobe, one clock wide, 16 per bit period.
tx_start  input  1  request to send; sampled only in Idle.
data_i  input  N_BITS_DATA  byte to send; latched when tx_start is accepted.
tx_o  output  1  serial line, idle high, registered.
tx_busy  output  1  high whenever state != Idle.
tx_done_tick  output  1  one-clock pulse at frame end.

Behaviour:
- Reset (synchronous, active-high):
  - Applies at the next clock edge.
  - state=Idle, tx_o=1, tx_busy=0, tx_done_tick=0, tick/bit counters=0, shift register=0.
  - Reset mid-frame aborts the frame: tx_o=1 on the following cycle, no tx_done_tick.
- States (one-hot): Idle 00001, Start 00010, Data 00100, Parity 01000, Stop 10000.
- Idle:
  - tx_o=1.
  - On a clock edge with tx_start=1: latch data_i into the shift register and compute parity = ^data_i XOR PARITY_ODD (registered).
  - Clear the tick counter and go to Start.
  - tx_o goes low on the cycle after acceptance; s_ticks is not required for the transition.
- Tick counter:
  - Increments only on cycles with s_ticks=1 in non-Idle states.
  - Wraps from 15 to 0. The wrap edge is the "bit end".
  - Cleared in Idle.
  - Clock cycles without s_ticks hold all state.
- Start: tx_o=0; at bit end go to Data with bit counter=0.
- Data:
  - tx_o = shift_reg[0].
  - At each bit end: shift right and increment the bit counter.
  - At the bit end where bit counter == N_BITS_DATA-1, go to Parity if PARITY_EN=1, else to Stop.
- Parity: tx_o = latched parity bit; at bit end go to Stop.
- Stop:
  - tx_o=1; at bit end go to Idle.
  - tx_done_tick=1 for exactly the one clock following that edge.
- Frame length: 11x16 = 176 s_ticks with parity; 160 s_ticks without.
- tx_o changes only at state/bit boundaries; it never glitches within a bit.
- tx_start while busy: ignored, no queuing. data_i changes while busy do not affect the frame in flight.
- Back-to-back frames: tx_start held high (or asserted) in the tx_done_tick cycle is accepted at the next edge. The inter-frame gap is one clock plus the remaining tick-phase; no extra stop time is inserted.
- tx_start and reset together: reset wins.

Test Plan:
- Reset: assert reset mid-Data → next cycle tx_o=1, tx_busy=0, tx_done_tick never pulses; a subsequent tx_start is accepted normally.
- Even parity: data_i=0xA5, one tx_start pulse → tx_o sequence 0,1,0,1,0,0,1,0,1,0(parity),1. Each bit is held exactly 16 s_ticks; tx_done_tick pulses once, 176 s_ticks after start.
- Odd parity (PARITY_ODD=1): data_i=0x01 → parity bit 0; data_i=0x00 → parity bit 1.
- PARITY_EN=0: data_i=0xFF → 0,1x8,1 (160 s_ticks), no parity slot.
- Busy rules: tx_start pulsed mid-frame with data_i=0x3C → ignored; the current frame completes unchanged and no second frame follows.
- Back-to-back loopback: tx_o → UART receiver on the same s_ticks; hold tx_start high for 0x55 then 0xC3 → receiver outputs 0x55 then 0xC3, tx_done_tick pulses twice, no framing errors.
